turn_controller: RTL and testbench
==================================

# turn_controller

Sequences a Connect-4 game from the debounced single-cycle move pulses (left/right/put) produced by the input-conditioning block. Owns the cursor column, current player, per-column fill heights and the move counter. Issues one write transaction per accepted move to the board memory, then one check request to the win checker, and decides next turn, win or draw. Sits between input conditioning and the board/VGA datapath.

## Interface
- COLS, 7, number of board columns (2..15)
- ROWS, 6, number of board rows (2..15)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- left_pulse  in  1  move cursor left, one-cycle pulse
- right_pulse  in  1  move cursor right, one-cycle pulse
- put_pulse  in  1  drop disc at cursor, one-cycle pulse
- new_game  in  1  synchronous restart, one-cycle pulse
- cursor_col  out  $clog2(COLS)  current cursor column
- player  out  1  player to move (0/1)
- wr_req  out  1  board write request, held until acked
- wr_row  out  $clog2(ROWS)  target row (0 = bottom), stable while wr_req
- wr_col  out  $clog2(COLS)  target column, stable while wr_req
- wr_player  out  1  disc owner, stable while wr_req
- wr_ack  in  1  board write accepted
- chk_req  out  1  win-check start, one-cycle pulse
- chk_done  in  1  win-check result valid, one-cycle pulse
- chk_win  in  1  last disc completed four-in-a-row; valid with chk_done
- game_over  out  1  game finished
- winner_valid  out  1  game ended with a winner (0 with game_over = draw)
- winner  out  1  winning player, valid with winner_valid

## Operation
- States: SELECT, WRITE, CHECK, OVER. Reset enters SELECT.
- Reset values: cursor_col 0, player 0, all heights 0, move counter 0, wr_req 0, wr_row/wr_col/wr_player 0, chk_req 0, game_over 0, winner_valid 0, winner 0.
- SELECT: input priority put > left > right; left and right in the same cycle without put is ignored.
  - left: cursor_col decrements; at 0 saturates (see Configuration).
  - right: cursor_col increments; at COLS-1 saturates.
  - put with height[cursor_col] < ROWS: latch wr_row = height, wr_col = cursor_col, wr_player = player; go to WRITE.
  - put with height[cursor_col] == ROWS (full column): ignored, stay in SELECT.
- WRITE: wr_req high, outputs stable. When wr_ack is sampled high: height[wr_col] += 1, move counter += 1, go to CHECK. Cursor pulses are ignored.
- CHECK: chk_req pulses in the first cycle only. Wait for chk_done, which may arrive in the chk_req cycle or later.
  - chk_win=1: go to OVER, winner_valid=1, winner=wr_player.
  - Otherwise, if move counter == ROWS*COLS: go to OVER with a draw.
  - Otherwise toggle player and return to SELECT; cursor_col is kept.
- OVER: game_over=1; all move pulses are ignored.
- new_game in any state takes priority over everything else. It has the same effect as reset: wr_req drops in the next cycle even if unacked, and a later stray wr_ack or chk_done in SELECT is ignored. Board memory clearing is external.
- Move counter width: $clog2(ROWS*COLS+1); heights width: $clog2(ROWS+1).

## Timing
- All outputs are registered.
- put_pulse at cycle N (legal): wr_req=1 at N+1.
- wr_ack at cycle M: wr_req=0 and chk_req=1 at M+1; the updated height is visible at M+1.
- chk_done at cycle K: next state is effective at K+1 (player toggled, or game_over=1).
- Cursor move: left/right at N changes cursor_col at N+1.
- Throughput: one move per 3 cycles minimum (SELECT→WRITE→CHECK with same-cycle ack/done).

## Configuration
- CURSOR_WRAP_EN defined: left at column 0 goes to COLS-1; right at COLS-1 goes to 0.
- CURSOR_WRAP_EN undefined: the cursor saturates at both edges.

## Structure
- Shared package connect4_pkg holds:
  - state enum ctrl_state_t (SELECT, WRITE, CHECK, OVER)
  - default COLS/ROWS localparams
  - player_t typedef
- Sub-module col_height_tracker: a COLS-entry height register file with clear, increment-on-write and full flags. It is instantiated once.

## Test plan
- Reset, then 3× right_pulse, then 1× left_pulse → cursor_col 2, player 0, all outputs at reset values until the first pulse.
- put at col 2 with wr_ack delayed 4 cycles → wr_req held 5 cycles with wr_row 0, wr_col 2, wr_player 0; chk_req one cycle; chk_done with win=0 → player 1.
- Six puts into col 0 (alternating players, no win), then a 7th put → 7th put ignored, wr_req stays 0, state SELECT.
- Player 0 wins on vertical four (checker model returns chk_win=1 on the 7th move) → game_over=1, winner_valid=1, winner=0; subsequent put/left pulses are ignored.
- Fill all 42 cells with chk_win=0 → game_over=1, winner_valid=0 after 42nd chk_done.
- new_game during WRITE (no ack) → wr_req=0 next cycle, heights 0, player 0; a late wr_ack has no effect. Run with and without CURSOR_WRAP_EN: left at col 0 gives col 6 (wrap) or col 0 (saturate).

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared types and defaults for the Connect-4 game controller.
// Contents: controller state enum, default board dimensions, player type.
// Imported by col_height_tracker and turn_controller.
package connect4_pkg;

  // Controller phases: choose column, write disc, run win check, game finished.
  typedef enum logic [1:0] {
    SELECT = 2'd0,
    WRITE  = 2'd1,
    CHECK  = 2'd2,
    OVER   = 2'd3
  } ctrl_state_t;

  localparam int DEF_COLS = 7;
  localparam int DEF_ROWS = 6;

  // One bit identifies the disc owner: player 0 or player 1.
  typedef logic player_t;

endpackage

// File: rtl/col_height_tracker.sv
// Per-column fill-height register file for the Connect-4 board.
// Ports: clk/rst (async active-low), clr (sync clear), inc/inc_col (add one disc),
//        rd_col -> rd_height (combinational read), full (one flag per column).
module col_height_tracker
  import connect4_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  localparam int CW = $clog2(COLS),
  localparam int HW = $clog2(ROWS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  input  logic [CW-1:0]   inc_col,
  input  logic [CW-1:0]   rd_col,
  output logic [HW-1:0]   rd_height,
  output logic [COLS-1:0] full
);

  localparam logic [HW-1:0] MAX_H = HW'(ROWS);

  logic [HW-1:0] heights [COLS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < COLS; i++) heights[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < COLS; i++) heights[i] <= '0;
    end else if (inc && (int'(inc_col) < COLS)) begin
      // A full column never gets a write, but never wrap past ROWS regardless.
      if (heights[inc_col] != MAX_H) heights[inc_col] <= heights[inc_col] + HW'(1);
    end
  end

  always_comb begin
    full = '0;
    for (int i = 0; i < COLS; i++) full[i] = (heights[i] == MAX_H);
  end

  assign rd_height = heights[rd_col];

endmodule

// File: rtl/turn_controller.sv
// Connect-4 turn sequencer: cursor, current player, column heights, move count,
// board write handshake, win-check handshake and win/draw decision.
// Ports: clk/rst (async active-low); left/right/put_pulse, new_game in;
//        cursor_col, player out; wr_req/row/col/player out, wr_ack in;
//        chk_req out, chk_done/chk_win in; game_over/winner_valid/winner out.
// Optional feature: define CURSOR_WRAP_EN to make the cursor wrap at both edges
// (default build saturates).
module turn_controller
  import connect4_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          left_pulse,
  input  logic          right_pulse,
  input  logic          put_pulse,
  input  logic          new_game,
  output logic [CW-1:0] cursor_col,
  output player_t       player,
  output logic          wr_req,
  output logic [RW-1:0] wr_row,
  output logic [CW-1:0] wr_col,
  output player_t       wr_player,
  input  logic          wr_ack,
  output logic          chk_req,
  input  logic          chk_done,
  input  logic          chk_win,
  output logic          game_over,
  output logic          winner_valid,
  output player_t       winner
);

  localparam int HW = $clog2(ROWS + 1);
  localparam int MW = $clog2(ROWS * COLS + 1);
  localparam logic [MW-1:0] CELLS    = MW'(ROWS * COLS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  ctrl_state_t   state;
  logic [MW-1:0] moves;
  logic [HW-1:0] col_height;
  logic [COLS-1:0] col_full;
  logic          trk_inc;

  // The height update coincides with the accepted write, so the new height is
  // visible the cycle after wr_ack together with chk_req.
  assign trk_inc = (state == WRITE) && wr_ack && !new_game;

  col_height_tracker #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_heights (
    .clk       (clk),
    .rst       (rst),
    .clr       (new_game),
    .inc       (trk_inc),
    .inc_col   (wr_col),
    .rd_col    (cursor_col),
    .rd_height (col_height),
    .full      (col_full)
  );

  function automatic logic [CW-1:0] col_left(input logic [CW-1:0] c);
    if (c == '0) begin
`ifdef CURSOR_WRAP_EN
      return LAST_COL;
`else
      return c;
`endif
    end
    return c - CW'(1);
  endfunction

  function automatic logic [CW-1:0] col_right(input logic [CW-1:0] c);
    if (c == LAST_COL) begin
`ifdef CURSOR_WRAP_EN
      return '0;
`else
      return c;
`endif
    end
    return c + CW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= SELECT;
      moves        <= '0;
      cursor_col   <= '0;
      player       <= 1'b0;
      wr_req       <= 1'b0;
      wr_row       <= '0;
      wr_col       <= '0;
      wr_player    <= 1'b0;
      chk_req      <= 1'b0;
      game_over    <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= 1'b0;
    end else if (new_game) begin
      // Restart overrides everything, including an unacknowledged write.
      state        <= SELECT;
      moves        <= '0;
      cursor_col   <= '0;
      player       <= 1'b0;
      wr_req       <= 1'b0;
      wr_row       <= '0;
      wr_col       <= '0;
      wr_player    <= 1'b0;
      chk_req      <= 1'b0;
      game_over    <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= 1'b0;
    end else begin
      case (state)
        SELECT: begin
          if (put_pulse) begin
            // A put on a full column is swallowed, and it still masks
            // any cursor pulse arriving in the same cycle.
            if (!col_full[cursor_col]) begin
              wr_req    <= 1'b1;
              wr_row    <= RW'(col_height);
              wr_col    <= cursor_col;
              wr_player <= player;
              state     <= WRITE;
            end
          end else if (left_pulse && !right_pulse) begin
            cursor_col <= col_left(cursor_col);
          end else if (right_pulse && !left_pulse) begin
            cursor_col <= col_right(cursor_col);
          end
        end

        WRITE: begin
          if (wr_ack) begin
            wr_req  <= 1'b0;
            chk_req <= 1'b1;
            moves   <= moves + MW'(1);
            state   <= CHECK;
          end
        end

        CHECK: begin
          chk_req <= 1'b0;
          if (chk_done) begin
            if (chk_win) begin
              state        <= OVER;
              game_over    <= 1'b1;
              winner_valid <= 1'b1;
              winner       <= wr_player;
            end else if (moves == CELLS) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              player <= ~player;
              state  <= SELECT;
            end
          end
        end

        OVER: begin
          // Only reset or new_game leave this state.
        end

        default: state <= SELECT;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
module tb_turn_controller;

  localparam int COLS = 7;
  localparam int ROWS = 6;

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       left_pulse, right_pulse, put_pulse, new_game;
  logic [2:0] cursor_col;
  logic       player;
  logic       wr_req;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic       wr_player;
  logic       wr_ack;
  logic       chk_req;
  logic       chk_done, chk_win;
  logic       game_over, winner_valid, winner;

  always #5 clk = ~clk;

  turn_controller #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk          (clk),
    .rst          (rst),
    .left_pulse   (left_pulse),
    .right_pulse  (right_pulse),
    .put_pulse    (put_pulse),
    .new_game     (new_game),
    .cursor_col   (cursor_col),
    .player       (player),
    .wr_req       (wr_req),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_player    (wr_player),
    .wr_ack       (wr_ack),
    .chk_req      (chk_req),
    .chk_done     (chk_done),
    .chk_win      (chk_win),
    .game_over    (game_over),
    .winner_valid (winner_valid),
    .winner       (winner)
  );

  int errors = 0;
  int checks = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Game model: tracks the game in terms of board heights, moves played and
  // which handshake is outstanding (0 choose, 1 awaiting write, 2 awaiting check,
  // 3 finished), and derives what each output must show.
  // ---------------------------------------------------------------------------
  int m_h [COLS];
  int m_moves, m_phase, m_cur, m_pl;
  int m_wr_req, m_row, m_col, m_wp, m_chk, m_over, m_wv, m_win;

  task automatic model_reset();
    for (int i = 0; i < COLS; i++) m_h[i] = 0;
    m_moves = 0; m_phase = 0; m_cur = 0; m_pl = 0;
    m_wr_req = 0; m_row = 0; m_col = 0; m_wp = 0; m_chk = 0;
    m_over = 0; m_wv = 0; m_win = 0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst || new_game) begin
      model_reset();
    end else begin
      if (m_phase == 0) begin
        if (put_pulse) begin
          if (m_h[m_cur] < ROWS) begin
            m_wr_req = 1; m_row = m_h[m_cur]; m_col = m_cur; m_wp = m_pl;
            m_phase = 1;
          end
        end else if (left_pulse && !right_pulse) begin
          m_cur = (m_cur == 0) ? (WRAP ? COLS - 1 : 0) : m_cur - 1;
        end else if (right_pulse && !left_pulse) begin
          m_cur = (m_cur == COLS - 1) ? (WRAP ? 0 : COLS - 1) : m_cur + 1;
        end
      end else if (m_phase == 1) begin
        if (wr_ack) begin
          m_h[m_col]++; m_moves++;
          m_wr_req = 0; m_chk = 1; m_phase = 2;
        end
      end else if (m_phase == 2) begin
        m_chk = 0;
        if (chk_done) begin
          if (chk_win) begin
            m_over = 1; m_wv = 1; m_win = m_wp; m_phase = 3;
          end else if (m_moves == ROWS * COLS) begin
            m_over = 1; m_phase = 3;
          end else begin
            m_pl = 1 - m_pl; m_phase = 0;
          end
        end
      end
    end
  end

  // Every cycle: all outputs against the model.
  always @(negedge clk) begin
    cmp("cursor_col", cursor_col, m_cur);
    cmp("player", player, m_pl);
    cmp("wr_req", wr_req, m_wr_req);
    cmp("wr_row", wr_row, m_row);
    cmp("wr_col", wr_col, m_col);
    cmp("wr_player", wr_player, m_wp);
    cmp("chk_req", chk_req, m_chk);
    cmp("game_over", game_over, m_over);
    cmp("winner_valid", winner_valid, m_wv);
    cmp("winner", winner, m_win);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input bit l, r, p, ng, ak, dn, wn);
    left_pulse = l; right_pulse = r; put_pulse = p; new_game = ng;
    wr_ack = ak; chk_done = dn; chk_win = wn;
    @(negedge clk);
    #1;
    left_pulse = 0; right_pulse = 0; put_pulse = 0; new_game = 0;
    wr_ack = 0; chk_done = 0; chk_win = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic goto_col(input int c);
    for (int k = 0; k < 2 * COLS && m_cur != c; k++) begin
      if (m_cur < c) drive(0, 1, 0, 0, 0, 0, 0);
      else           drive(1, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic play(input int c, input int ackd, input int doned, input bit win);
    goto_col(c);
    drive(0, 0, 1, 0, 0, 0, 0);
    idle(ackd);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(doned);
    drive(0, 0, 0, 0, 0, 1, win);
  endtask

  initial begin
    int hold;
    rst = 1'b0;
    left_pulse = 0; right_pulse = 0; put_pulse = 0; new_game = 0;
    wr_ack = 0; chk_done = 0; chk_win = 0;
    repeat (3) @(negedge clk);
    #1;
    cmp("reset cursor_col", cursor_col, 0);
    cmp("reset wr_req", wr_req, 0);
    cmp("reset game_over", game_over, 0);
    rst = 1'b1;
    idle(2);
    cmp("idle player", player, 0);

    // Cursor: 3 right, 1 left, then a left+right collision that must be ignored.
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    cmp("cursor after 3R1L", cursor_col, 2);
    drive(1, 1, 0, 0, 0, 0, 0);
    cmp("cursor after L+R", cursor_col, 2);

    // Put at column 2 with a delayed acknowledge.
    hold = 0;
    drive(0, 0, 1, 0, 0, 0, 0);
    hold += wr_req;
    cmp("first put wr_row", wr_row, 0);
    cmp("first put wr_col", wr_col, 2);
    cmp("first put wr_player", wr_player, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);  // cursor pulse during write is ignored
      hold += wr_req;
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    cmp("wr_req cycles", hold, 5);
    cmp("wr_req after ack", wr_req, 0);
    cmp("chk_req after ack", chk_req, 1);
    idle(1);
    cmp("chk_req one cycle", chk_req, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    cmp("player after move 1", player, 1);
    cmp("cursor kept", cursor_col, 2);

    // Fill column 0, then a seventh put must be ignored.
    drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < ROWS; i++) play(0, i % 2, i % 3, 1'b0);
    cmp("player after 6", player, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    cmp("full col wr_req", wr_req, 0);
    idle(2);
    cmp("full col still idle", wr_req, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    cmp("select after full put", cursor_col, 1);

    // Vertical win for player 0 on move 7.
    drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) play(i % 2, 0, 0, 1'b0);
    play(0, 0, 0, 1'b1);
    cmp("win game_over", game_over, 1);
    cmp("win winner_valid", winner_valid, 1);
    cmp("win winner", winner, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    cmp("over wr_req", wr_req, 0);
    cmp("over cursor", cursor_col, 0);

    // Draw: fill all cells with no win.
    drive(0, 0, 0, 1, 0, 0, 0);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) play(c, 0, 0, 1'b0);
    cmp("draw game_over", game_over, 1);
    cmp("draw winner_valid", winner_valid, 0);

    // Restart, edge behaviour of the cursor, and abort of a pending write.
    drive(0, 0, 0, 1, 0, 0, 0);
    cmp("restart cursor", cursor_col, 0);
    cmp("restart game_over", game_over, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    cmp("left at col 0", cursor_col, WRAP ? 6 : 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    cmp("right after edge", cursor_col, WRAP ? 0 : 1);
    drive(0, 0, 1, 0, 0, 0, 0);
    cmp("abort put wr_req", wr_req, 1);
    idle(2);
    drive(0, 0, 0, 1, 0, 0, 0);
    cmp("abort wr_req", wr_req, 0);
    cmp("abort player", player, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    cmp("stray ack chk_req", chk_req, 0);
    cmp("stray ack wr_req", wr_req, 0);
    cmp("stray done player", player, 0);
    goto_col(3);
    drive(0, 0, 1, 0, 0, 0, 0);
    cmp("post-restart wr_row", wr_row, 0);
    cmp("post-restart wr_col", wr_col, 3);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    cmp("post-restart player", player, 1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
